// File: rtl/reflet_loader_pkg.sv
// reflet_loader_pkg: shared types and timing helpers for the UART boot loader.
package reflet_loader_pkg;

    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA_LO, DATA_HI, WRITE, DONE, ERROR} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int bytes_per_word(input int wordsize);
        return wordsize / 8;
    endfunction

    // Values for the default configuration; modules derive their own from their parameters.
    localparam int BIT_PERIOD     = bit_period(1000000, 9600);
    localparam int BYTES_PER_WORD = bytes_per_word(16);

endpackage

// File: rtl/reflet_uart_rx_core.sv
// reflet_uart_rx_core: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and glitch rejection.
module reflet_uart_rx_core
    import reflet_loader_pkg::*;
#(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int P  = bit_period(clk_freq, baud_rate);
    localparam int CW = $clog2(P + 1);

    rx_state_t     st_q;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx_s;
    logic          half;
    logic          full;

    // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection.
    assign rx_s       = sync_q[1];
    assign half       = cnt_q == CW'(P / 2 - 1);
    assign full       = cnt_q == CW'(P - 1);
    assign byte_valid = valid_q;
    assign byte_data  = sh_q;
    assign frame_err  = ferr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= RX_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (st_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (sync_q[2] && !rx_s) st_q <= RX_START;
                end
                RX_START: if (half) begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    st_q  <= rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (full) begin
                    cnt_q <= '0;
                    sh_q  <= {rx_s, sh_q[7:1]};
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) st_q <= RX_STOP;
                end
                RX_STOP: if (full) begin
                    cnt_q   <= '0;
                    st_q    <= RX_IDLE;
                    valid_q <= rx_s;
                    ferr_q  <= !rx_s;
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reflet_uart_loader.sv
// reflet_uart_loader: receives a length-prefixed image over UART, writes it to RAM, then enables the CPU.
module reflet_uart_loader
    import reflet_loader_pkg::*;
#(
    parameter int                   clk_freq  = 1000000,
    parameter int                   baud_rate = 9600,
    parameter int                   wordsize  = 16,
    parameter int                   addr_size = 16,
    parameter logic [addr_size-1:0] base_addr = 16'h8000,
    parameter int                   max_words = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [addr_size-1:0] addr,
    output logic [wordsize-1:0]  data_out,
    output logic                 write_en,
    output logic                 cpu_enable,
    output logic                 busy,
    output logic                 error
);

    localparam int BPW = bytes_per_word(wordsize);

    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 frame_err;
    state_t               state_q;
    logic [15:0]          len_q;
    logic [15:0]          idx_q;
    logic [7:0]           lo_q;
    logic [15:0]          hdr;
    logic [addr_size-1:0] addr_q;
    logic [wordsize-1:0]  data_q;
    logic                 we_q;
    logic                 cpu_q;
    logic                 busy_q;
    logic                 err_q;

    reflet_uart_rx_core #(.clk_freq(clk_freq), .baud_rate(baud_rate)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign hdr        = {byte_data, len_q[7:0]};
    assign addr       = addr_q;
    assign data_out   = data_q;
    assign write_en   = we_q;
    assign cpu_enable = cpu_q;
    assign busy       = busy_q;
    assign error      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR_LO;
            len_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            cpu_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (frame_err && state_q != DONE && state_q != ERROR) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            cpu_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                HDR_LO: if (byte_valid) begin
                    len_q[7:0] <= byte_data;
                    busy_q     <= 1'b1;
                    state_q    <= HDR_HI;
                end
                HDR_HI: if (byte_valid) begin
                    len_q <= hdr;
                    idx_q <= '0;
                    if (int'(hdr) > max_words) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (hdr == '0) begin
                        state_q <= DONE;
                        cpu_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA_LO;
                    end
                end
                DATA_LO: if (byte_valid) begin
                    lo_q    <= byte_data;
                    state_q <= DATA_HI;
                end
                DATA_HI: if (byte_valid) begin
                    addr_q  <= base_addr + addr_size'(int'(idx_q) * BPW);
                    data_q  <= wordsize'({byte_data, lo_q});
                    we_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    we_q  <= 1'b0;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q + 1'b1 == len_q) begin
                        state_q <= DONE;
                        cpu_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA_LO;
                    end
                end
                DONE, ERROR: state_q <= state_q;
                default: state_q <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_uart_loader.sv
// tb_reflet_uart_loader: directed image loads against a byte-level model of the loader's write stream.
module tb_reflet_uart_loader;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] addr;
    logic [15:0] data_out;
    logic        write_en;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          exp_words = 0;
    int          n_writes = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] last_data = '0;
    logic        prev_we = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_cpu = 1'b0;

    reflet_uart_loader #(
        .clk_freq  (96000),
        .baud_rate (9600),
        .wordsize  (16),
        .addr_size (16),
        .base_addr (16'h8000),
        .max_words (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .addr       (addr),
        .data_out   (data_out),
        .write_en   (write_en),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the header gives L words; each accepted word lands at base + 2*i, little-endian.
    task automatic expect_image(input logic [7:0] bs[$]);
        int l;
        l = {bs[1], bs[0]};
        exp_words = (l > 100) ? 0 : l;
        for (int i = 0; i < exp_words; i++)
            exp_q.push_back({16'h8000 + 16'(2 * i), bs[3 + 2 * i], bs[2 + 2 * i]});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk) rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (P) @(negedge clk);
        end
        rx = stop;
        repeat (P) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_all(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk(name, {addr, data_out, write_en, cpu_enable, busy, error}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_words = 0;
        n_writes = 0;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (write_en) begin
                n_writes++;
                last_addr = addr;
                last_data = data_out;
                if (exp_q.size() == 0) chk("write_unexpected", 64'(exp_q.size()), 64'd1);
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(addr), 64'(e[31:16]));
                    chk("write_data", 64'(data_out), 64'(e[15:0]));
                end
            end
            if (cpu_enable && !prev_cpu) begin
                chk("cpu_rise_busy_fall", {prev_busy, busy}, 64'b10);
                chk("cpu_rise_after_write", 64'(prev_we), 64'(exp_words > 0));
            end
            if (error || cpu_enable) chk("terminal_flags", {busy, error & cpu_enable}, 64'd0);
        end
        prev_we   = reset ? 1'b0 : write_en;
        prev_busy = reset ? 1'b0 : busy;
        prev_cpu  = reset ? 1'b0 : cpu_enable;
    end

    task automatic end_check(input string t, input logic exp_cpu, input logic exp_err, input int exp_n);
        chk({t, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({t, "_cpu_enable"}, 64'(cpu_enable), 64'(exp_cpu));
        chk({t, "_error"}, 64'(error), 64'(exp_err));
        chk({t, "_busy"}, 64'(busy), 64'd0);
        chk({t, "_writes"}, 64'(n_writes), 64'(exp_n));
    endtask

    initial begin
        logic [7:0] img[$];
        do_reset("reset_state");

        img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        expect_image(img);
        send_byte(img[0]);
        chk("t1_busy_after_hdr_lo", 64'(busy), 64'd1);
        img.pop_front();
        send_all(img);
        end_check("t1", 1'b1, 1'b0, 2);
        chk("t1_last_write", {last_addr, last_data}, 64'h8002_ABCD);

        do_reset("reset_t2");
        img = '{8'h00, 8'h00};
        expect_image(img);
        send_byte(img[0]);
        send_byte(img[1]);
        chk("t2_cpu_after_hdr", 64'(cpu_enable), 64'd1);
        end_check("t2", 1'b1, 1'b0, 0);

        do_reset("reset_t3");
        img = '{8'h65, 8'h00};
        expect_image(img);
        send_all(img);
        chk("t3_error_after_hdr", 64'(error), 64'd1);
        send_all('{8'h02, 8'h00, 8'h34, 8'h12});
        end_check("t3", 1'b0, 1'b1, 0);

        do_reset("reset_t4");
        img = '{8'h01, 8'h00};
        expect_image(img);
        exp_q.delete();
        send_all(img);
        send_byte(8'h55, 1'b0);
        repeat (5) @(negedge clk);
        end_check("t4", 1'b0, 1'b1, 0);

        do_reset("reset_t5");
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_glitch_busy", {busy, error}, 64'd0);
        img = '{8'h01, 8'h00, 8'h78, 8'h56};
        expect_image(img);
        send_all(img);
        end_check("t5", 1'b1, 1'b0, 1);
        chk("t5_last_write", {last_addr, last_data}, 64'h8000_5678);

        do_reset("reset_t6");
        send_all('{8'h01, 8'h00, 8'hEF});
        chk("t6_busy_mid_load", 64'(busy), 64'd1);
        @(negedge clk) rx = 1'b0;
        repeat (3 * P) @(negedge clk);
        do_reset("t6_reset_abort");
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        expect_image(img);
        send_all(img);
        end_check("t6", 1'b1, 1'b0, 1);
        chk("t6_last_write", {last_addr, last_data}, 64'h8000_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
